// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, branch redirect with squash, stall hold.
// Optional FETCH_TIMEOUT_EN macro adds an ack-timeout counter that parks the FSM in HALT.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch,
   input  logic        zero,
   input  logic [31:0] branchDest,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        redirect;
   logic [31:0] target;

`ifdef FETCH_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;
   logic        fault_q, fault_d;
`endif

   assign redirect = branch & zero;
   assign target   = branchDest & 32'hFFFF_FFFC;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      valid_d      = valid_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d        = 32'd0;
      fault_d      = fault_q;
`endif
      case (state_q)
         IDLE: begin
            if (redirect) begin
               pc_d    = target;
               valid_d = 1'b0;
            end
            if (!stall) state_d = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               // A redirect seen now or earlier in this fetch turns the returned word into a squash.
               if (redirect) begin
                  pc_d    = target;
                  valid_d = 1'b0;
               end else if (pend_valid_q) begin
                  pc_d    = pend_pc_q;
                  valid_d = 1'b0;
               end else begin
                  instr_d = imem_rdata;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  if (stall) state_d = HOLD;
               end
               pend_valid_d = 1'b0;
            end else begin
               valid_d = 1'b0;
               if (redirect) begin
                  pend_valid_d = 1'b1;
                  pend_pc_d    = target;
               end
`ifdef FETCH_TIMEOUT_EN
               if (cnt_q == 32'(TIMEOUT - 1)) begin
                  fault_d = 1'b1;
                  state_d = HALT;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
`endif
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = target;
               valid_d = 1'b0;
            end
            if (!stall) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_d = (state_d == FETCH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         instr_q      <= 32'd0;
         valid_q      <= 1'b0;
         req_q        <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q        <= 32'd0;
         fault_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
         req_q        <= req_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q        <= cnt_d;
         fault_q      <= fault_d;
`endif
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;

`ifdef FETCH_TIMEOUT_EN
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule
